// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision sequential adder and its neighbours.
package mp_add_seq_pkg;

  // Width of one datapath word handled per beat.
  localparam int unsigned WORD_W = 64;

  // Beat counter width; covers up to 16 words per operand.
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Two's-complement overflow of a + b' given the operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mp_add_seq_csa.sv
// 64-bit carry-select adder with zero flag: low half ripples, high half is
// precomputed for both carry-ins and selected by the low-half carry-out.
module mp_add_seq_csa
  import mp_add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_y,
  output logic              o_cout,
  output logic              o_z
);

  localparam int unsigned Half = WORD_W / 2;

  logic [Half:0] w_lo;
  logic [Half:0] w_hi0;
  logic [Half:0] w_hi1;
  logic [Half:0] w_hi;

  assign w_lo  = {1'b0, i_a[Half-1:0]} + {1'b0, i_b[Half-1:0]} + {{Half{1'b0}}, i_cin};
  assign w_hi0 = {1'b0, i_a[WORD_W-1:Half]} + {1'b0, i_b[WORD_W-1:Half]};
  assign w_hi1 = {1'b0, i_a[WORD_W-1:Half]} + {1'b0, i_b[WORD_W-1:Half]}
               + {{Half{1'b0}}, 1'b1};
  assign w_hi  = w_lo[Half] ? w_hi1 : w_hi0;

  assign o_y    = {w_hi[Half-1:0], w_lo[Half-1:0]};
  assign o_cout = w_hi[Half];
  assign o_z    = (o_y == '0);

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision sequential adder/subtractor. Accepts a WORDS*64-bit operand
// pair, adds it one 64-bit word per cycle LSW first through a single
// carry-select adder, and presents the registered sum with carry/zero/overflow.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [WORD_W*WORDS-1:0] i_a,
  input  logic [WORD_W*WORDS-1:0] i_b,
  input  logic                    i_cin,
  input  logic                    i_sub,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [WORD_W*WORDS-1:0] o_sum,
  output logic                    o_cout,
  output logic                    o_zero,
  output logic                    o_ovf
);

  localparam int unsigned W = WORD_W * WORDS;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(WORDS - 1);

  state_e r_state;
  state_e w_state_d;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;     // already inverted for subtraction
  logic [W-1:0]      r_sum;
  logic              r_c;
  logic              r_zero_acc;
  logic              r_cout;
  logic              r_zero;
  logic              r_ovf;
  logic [BEAT_W-1:0] r_beat;

  logic [WORD_W-1:0] w_word_a;
  logic [WORD_W-1:0] w_word_b;
  logic [WORD_W-1:0] w_y;
  logic              w_cout;
  logic              w_z;
  logic              w_accept;
  logic              w_run;
  logic              w_last;

  assign w_accept = (r_state == StIdle) && i_in_valid;
  assign w_run    = (r_state == StRun);
  assign w_last   = w_run && (r_beat == LastBeat);
  assign w_word_a = r_a[WORD_W*r_beat +: WORD_W];
  assign w_word_b = r_b[WORD_W*r_beat +: WORD_W];

  mp_add_seq_csa u_csa (
    .i_a    (w_word_a),
    .i_b    (w_word_b),
    .i_cin  (r_c),
    .o_y    (w_y),
    .o_cout (w_cout),
    .o_z    (w_z)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: accept in idle, run one beat per word, hold done until taken.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid) w_state_d = StRun;
      StRun:   if (r_beat == LastBeat) w_state_d = StDone;
      StDone:  if (i_out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    o_in_ready  = (r_state == StIdle);
    o_out_valid = (r_state == StDone);
  end

  // Operand capture, per-beat word accumulation and final flag capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_c        <= 1'b0;
      r_zero_acc <= 1'b0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_beat     <= '0;
    end else if (w_accept) begin
      r_a        <= i_a;
      r_b        <= i_sub ? ~i_b : i_b;
      r_c        <= i_sub | i_cin;
      r_zero_acc <= 1'b1;
      r_beat     <= '0;
    end else if (w_run) begin
      r_sum[WORD_W*r_beat +: WORD_W] <= w_y;
      r_c        <= w_cout;
      r_zero_acc <= r_zero_acc & w_z;
      if (w_last) begin
        // Flags are latched separately so they stay stable across the next accept.
        r_cout <= w_cout;
        r_zero <= r_zero_acc & w_z;
        r_ovf  <= signed_ovf(r_a[W-1], r_b[W-1], w_y[WORD_W-1]);
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_zero = r_zero;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq with WORDS=4 and a wide-integer reference model.
module tb_mp_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 64 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         zero;
  logic         ovf;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_sub       (sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_zero      (zero),
    .o_ovf       (ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: plain wide arithmetic. Unsigned carry/borrow from a W+1 bit
  // result, signed overflow from a sign-extended W+1 bit result.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fc, input logic fs);
    logic [W:0] u;
    logic [W:0] s;
    res_t       r;
    if (fs) begin
      u      = {1'b0, fa} - {1'b0, fb};
      s      = {fa[W-1], fa} - {fb[W-1], fb};
      r.cout = ~u[W];
    end else begin
      u      = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, fc};
      s      = {fa[W-1], fa} + {fb[W-1], fb} + {{W{1'b0}}, fc};
      r.cout = u[W];
    end
    r.sum  = u[W-1:0];
    r.zero = (r.sum == '0);
    r.ovf  = s[W] ^ s[W-1];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input res_t act, input res_t exp);
    chk({nm, ".sum"},  {1'b0, act.sum}, {1'b0, exp.sum});
    chk({nm, ".cout"}, {{W{1'b0}}, act.cout}, {{W{1'b0}}, exp.cout});
    chk({nm, ".zero"}, {{W{1'b0}}, act.zero}, {{W{1'b0}}, exp.zero});
    chk({nm, ".ovf"},  {{W{1'b0}}, act.ovf},  {{W{1'b0}}, exp.ovf});
  endtask

  // Compare process: every valid output cycle is checked against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ready_valid_excl", {{W{1'b0}}, in_ready & out_valid}, '0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got out_valid=1 want no pending result");
        end else begin
          chk_res("result", {sum, cout, zero, ovf}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
      return;
    end
    a        = ta;
    b        = tb;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb, tc, ts));
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  // Waits for the result, holds it for 'hold' cycles, then accepts it.
  task automatic collect(input int hold, input bit chk_lat);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got out_valid=0 want 1");
      return;
    end
    if (chk_lat) chk("latency", (W+1)'(n + 1), (W+1)'(WORDS + 1));
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  localparam logic [W-1:0] AllOnes = {W{1'b1}};
  localparam logic [W-1:0] MaxPos  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinNeg  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] Word0F  = {{(W-64){1'b0}}, {64{1'b1}}};
  localparam logic [W-1:0] Bit64   = {{(W-65){1'b0}}, 1'b1, {64{1'b0}}};

  initial begin
    res_t r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    // Pin the reference model with hand-computed results.
    r = model(AllOnes, '0, 1'b1, 1'b0);
    chk_res("pin_ripple", r, {{W{1'b0}}, 1'b1, 1'b1, 1'b0});
    r = model(Word0F, W'(1), 1'b0, 1'b0);
    chk_res("pin_xword", r, {Bit64, 1'b0, 1'b0, 1'b0});
    r = model(W'(5), W'(7), 1'b1, 1'b1);
    chk_res("pin_borrow", r, {AllOnes - W'(1), 1'b0, 1'b0, 1'b0});
    r = model(W'(7), W'(5), 1'b0, 1'b1);
    chk_res("pin_noborrow", r, {W'(2), 1'b1, 1'b0, 1'b0});
    r = model(MaxPos, W'(1), 1'b0, 1'b0);
    chk_res("pin_ovf", r, {MinNeg, 1'b0, 1'b0, 1'b1});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));
    chk("rst.out_valid", {{W{1'b0}}, out_valid}, '0);
    chk_res("rst", {sum, cout, zero, ovf}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases; results checked by the compare process.
    send(AllOnes, '0, 1'b1, 1'b0);
    collect(0, 1'b1);
    send(Word0F, W'(1), 1'b0, 1'b0);
    collect(0, 1'b1);
    send(W'(5), W'(7), 1'b1, 1'b1);
    collect(0, 1'b0);
    send(W'(7), W'(5), 1'b0, 1'b1);
    collect(0, 1'b0);

    // Backpressure with stray in_valid pulses during RUN and DONE.
    send(MaxPos, W'(1), 1'b0, 1'b0);
    r        = model(MaxPos, W'(1), 1'b0, 1'b0);
    a        = AllOnes;
    b        = AllOnes;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("bp.out_valid", {{W{1'b0}}, out_valid}, (W+1)'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      chk("bp.in_ready", {{W{1'b0}}, in_ready}, '0);
      chk_res("bp.hold", {sum, cout, zero, ovf}, r);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.release_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));
    chk("bp.release_valid", {{W{1'b0}}, out_valid}, '0);

    // Reset during beat 2 discards the operation.
    send(AllOnes, AllOnes, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("mrst.in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));
    chk("mrst.out_valid", {{W{1'b0}}, out_valid}, '0);
    chk_res("mrst", {sum, cout, zero, ovf}, '0);
    rst_n = 1'b1;
    send(W'(1), W'(1), 1'b0, 1'b0);
    collect(0, 1'b1);

    // Randomized operations with random backpressure.
    for (int k = 0; k < 40; k++) begin
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      collect(int'($urandom_range(0, 3)), 1'b1);
    end

    chk("pending_results", (W+1)'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision sequential adder/subtractor that sits directly upstream of the 64-bit carry-select adder with zero flag. It accepts one wide operand pair through a valid/ready handshake and feeds it to the adder one 64-bit word per cycle, least-significant word first, chaining each word's carry-out into the next word's carry-in. It returns the registered wide sum with carry, zero and signed-overflow flags through a second valid/ready handshake.

## Interface
- WORDS, default 4: number of 64-bit words per operand; operand width W = 64*WORDS; legal range 2..16.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair and controls valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a+~b+1, cin ignored.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result, modulo 2^W.
- cout  out  1  carry out of bit W-1 (sub=1: 1 means no borrow).
- zero  out  1  sum == 0 across all W bits.
- ovf  out  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b' (b' = sub ? ~b : b), and carry register c = sub ? 1 : cin. Set beat=0 and zero_acc=1, then go to RUN.
- RUN, one word per cycle: adder inputs are a[64*beat +: 64], b'[64*beat +: 64] and c.
  - Store Y into sum[64*beat +: 64].
  - Set c <= adder cout and zero_acc <= zero_acc & adder Z.
  - If beat==WORDS-1, go to DONE; otherwise increment beat.
- DONE: out_valid=1, with cout=c and zero=zero_acc.
  - ovf = (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]).
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. in_ready and out_valid are never high together.
- sum, cout, zero and ovf stay stable from DONE entry until the next beat-0 write after a new accept. They are only meaningful while out_valid=1.
- A 4-bit beat counter is sufficient for WORDS≤16. No beat count wraps past WORDS-1.
- Reset, including mid-RUN or in DONE: state=IDLE, in_ready=1 on the cycle after rst_n samples low, out_valid=0, sum=0, cout=0, zero=0, ovf=0, beat=0, c=0. Any in-flight operation is discarded with no partial output.

## Timing
- Accept at edge t. RUN occupies edges t+1 .. t+WORDS. out_valid rises after edge t+WORDS.
- Latency from accept to out_valid: WORDS+1 cycles.
- With out_ready held high, a result is consumed on its first DONE cycle, and the next accept is possible at edge t+WORDS+2. Peak throughput is one operation per WORDS+2 cycles.
- All outputs are registered. The adder sits combinationally between the operand/carry registers and the sum/carry registers, so the critical path is one 64-bit adder.
- Backpressure: DONE persists indefinitely while out_ready=0, and outputs do not change.

## Structure
- Shared package holds:
  - WORD_W=64.
  - The FSM state enum (IDLE, RUN, DONE).
  - A helper function for the signed-overflow rule, which the future wide comparator also uses.
- One natural sub-module: the existing 64-bit carry-select adder with zero flag (A, B, cin → Y, cout, Z), instantiated once as the per-beat datapath.
- Operand registers, beat counter, carry/zero accumulators and FSM live in mp_add_seq itself.

## Test plan
All scenarios use WORDS=4 (W=256).
- Carry ripple: a = 2^256−1, b = 0, cin=1, sub=0 → sum=0, cout=1, zero=1, ovf=0; out_valid 5 cycles after accept.
- Cross-word carry: a = 2^64−1, b = 1, cin=0 → sum=2^64, cout=0, zero=0 (word 0 is zero but the total is nonzero).
- Subtract with borrow: a=5, b=7, sub=1 → sum = 2^256−2, cout=0, ovf=0; a=7, b=5, sub=1 → sum=2, cout=1.
- Signed overflow: a = 2^255−1, b=1, sub=0 → sum=2^255, ovf=1, cout=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0 throughout.
  - in_valid pulses during RUN/DONE are ignored.
  - Releasing out_ready returns to IDLE next cycle.
- Reset mid-operation: assert rst_n=0 at beat 2 → next cycle state IDLE, out_valid=0, sum=0, flags 0. A fresh a=1, b=1 then yields sum=2 after 5 cycles.
